// File: rtl/timer_capture.sv
// timer_capture: timestamps synchronized cap_in edges with count_value into a FWFT FIFO
module timer_capture #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     enable,
  input  logic [1:0]               edge_sel,
  input  logic                     cap_in,
  input  logic [WIDTH-1:0]         count_value,
  input  logic                     pop,
  output logic [WIDTH-1:0]         cap_data,
  output logic                     cap_valid,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SYNC_STAGES + 2);
  localparam logic [LW-1:0] FULL  = LW'(DEPTH);
  localparam logic [CW-1:0] ARM_N = CW'(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0] s;
  logic                   prev, s_last, armed, ev, do_pop, full, push, drop, ovf_nx;
  logic [CW-1:0]          arm;
  logic [AW-1:0]          wp, rp;
  logic [LW-1:0]          level_nx;
  logic [WIDTH-1:0]       mem [DEPTH];
  always_comb begin
    s_last    = s[SYNC_STAGES-1];
    armed     = arm == ARM_N;
    ev        = armed & enable & ((edge_sel[0] & s_last & ~prev) | (edge_sel[1] & ~s_last & prev));
    cap_valid = level != '0;
    do_pop    = pop & cap_valid;
    full      = level == FULL;
    push      = ev & (~full | do_pop);
    drop      = ev & full & ~do_pop;
    level_nx  = level + LW'(push) - LW'(do_pop);
    ovf_nx    = drop | (overflow & ~clr_overflow);
    cap_data  = cap_valid ? mem[rp] : '0;
  end
  // prev follows the synchronizer even while disarmed, so a level held through reset never looks like an edge
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s        <= '0;
      prev     <= 1'b0;
      arm      <= '0;
      wp       <= '0;
      rp       <= '0;
      level    <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      s        <= {s[SYNC_STAGES-2:0], cap_in};
      prev     <= s_last;
      arm      <= armed ? arm : arm + 1'b1;
      wp       <= push ? wp + 1'b1 : wp;
      rp       <= do_pop ? rp + 1'b1 : rp;
      level    <= level_nx;
      overflow <= ovf_nx;
      irq      <= (level_nx != '0) | ovf_nx;
    end
  end
  always_ff @(posedge wb_clk_i)
    if (push) mem[wp] <= count_value;
endmodule

// File: tb/tb_timer_capture.sv
// tb_timer_capture: directed checks of capture latency, FIFO ordering, overflow, reset and enable gating
module tb_timer_capture;
  logic        clk = 0, rst = 1, enable = 1, cap_in = 0, pop = 0, clr_overflow = 0;
  logic [1:0]  edge_sel = 2'b01;
  logic [31:0] count_value = 0, cap_data;
  logic        cap_valid, overflow, irq;
  logic [2:0]  level;
  int          vectors = 0, errors = 0;

  timer_capture dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .enable(enable), .edge_sel(edge_sel), .cap_in(cap_in),
    .count_value(count_value), .pop(pop), .cap_data(cap_data), .cap_valid(cap_valid),
    .level(level), .overflow(overflow), .clr_overflow(clr_overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // one toggle of cap_in with a held count; with edge_sel=11 this is exactly one event
  task automatic capture(input logic [31:0] v);
    count_value = v;
    cap_in = ~cap_in;
    tick(4);
  endtask

  task automatic do_pop();
    pop = 1;
    tick(1);
    pop = 0;
  endtask

  initial begin
    tick(3);
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(cap_valid), 0);
    chk("rst_data", cap_data, 0);
    chk("rst_irq", 32'(irq), 0);
    rst = 0;
    tick(5);
    // 1: single rising capture, falling edge ignored
    count_value = 32'hdcba7cfb;
    cap_in = 1;
    tick(5);
    cap_in = 0;
    tick(5);
    chk("t1_level", 32'(level), 1);
    chk("t1_data", cap_data, 32'hdcba7cfb);
    chk("t1_valid", 32'(cap_valid), 1);
    chk("t1_irq", 32'(irq), 1);
    do_pop();
    tick(1);
    chk("t1_pop_level", 32'(level), 0);
    chk("t1_pop_data", cap_data, 0);
    chk("t1_pop_irq", 32'(irq), 0);
    // 2: latency, first sample at count 0x1005 captures 0x1007
    for (int i = 0; i < 10; i++) begin
      count_value = 32'h1000 + 32'(i);
      if (i == 5) cap_in = 1;
      tick(1);
    end
    chk("t2_level", 32'(level), 1);
    chk("t2_data", cap_data, 32'h1007);
    do_pop();
    cap_in = 0;
    tick(4);
    chk("t2_empty", 32'(level), 0);
    // 3: overflow with five events and no pops
    edge_sel = 2'b11;
    capture(32'h19);
    capture(32'h0f);
    capture(32'h12bc);
    capture(32'h5d);
    capture(32'h259);
    chk("t3_level", 32'(level), 4);
    chk("t3_ovf", 32'(overflow), 1);
    chk("t3_d0", cap_data, 32'h19);
    do_pop();
    chk("t3_d1", cap_data, 32'h0f);
    do_pop();
    clr_overflow = 1;
    tick(1);
    clr_overflow = 0;
    tick(1);
    chk("t3_clr_ovf", 32'(overflow), 0);
    chk("t3_irq_held", 32'(irq), 1);
    chk("t3_d2", cap_data, 32'h12bc);
    do_pop();
    chk("t3_d3", cap_data, 32'h5d);
    do_pop();
    tick(1);
    chk("t3_empty", 32'(level), 0);
    chk("t3_irq_low", 32'(irq), 0);
    // 4: push and pop on the same edge while full
    capture(32'ha1);
    capture(32'ha2);
    capture(32'ha3);
    capture(32'ha4);
    chk("t4_full", 32'(level), 4);
    chk("t4_head", cap_data, 32'ha1);
    count_value = 32'hb5;
    cap_in = ~cap_in;
    tick(2);
    pop = 1;
    tick(1);
    pop = 0;
    tick(2);
    chk("t4_level", 32'(level), 4);
    chk("t4_ovf", 32'(overflow), 0);
    chk("t4_h1", cap_data, 32'ha2);
    do_pop();
    chk("t4_h2", cap_data, 32'ha3);
    do_pop();
    chk("t4_h3", cap_data, 32'ha4);
    do_pop();
    chk("t4_new", cap_data, 32'hb5);
    do_pop();
    chk("t4_empty", 32'(level), 0);
    // 5a: cap_in held high through reset release
    cap_in = 1;
    rst = 1;
    tick(3);
    rst = 0;
    tick(20);
    chk("t5_held_high", 32'(level), 0);
    // 5b: reset while level=3 and overflow=1
    capture(32'h1);
    capture(32'h2);
    capture(32'h3);
    capture(32'h4);
    capture(32'h5);
    do_pop();
    chk("t5_pre_level", 32'(level), 3);
    chk("t5_pre_ovf", 32'(overflow), 1);
    rst = 1;
    tick(1);
    rst = 0;
    chk("t5_level", 32'(level), 0);
    chk("t5_valid", 32'(cap_valid), 0);
    chk("t5_ovf", 32'(overflow), 0);
    chk("t5_irq", 32'(irq), 0);
    chk("t5_data", cap_data, 0);
    tick(5);
    // 6: enable gating
    enable = 0;
    cap_in = 0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      cap_in = ~cap_in;
      tick(2);
    end
    tick(4);
    chk("t6_disabled", 32'(level), 0);
    cap_in = 1;
    tick(4);
    enable = 1;
    tick(6);
    chk("t6_reenable", 32'(level), 0);
    edge_sel = 2'b10;
    count_value = 32'h77;
    cap_in = 0;
    tick(5);
    chk("t6_fall_level", 32'(level), 1);
    chk("t6_fall_data", cap_data, 32'h77);
    cap_in = 1;
    tick(5);
    chk("t6_rise_ignored", 32'(level), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/timer_capture.md
Name: timer_capture

Overview:
Input-capture stage that consumes the running value of a management-SoC counter/timer and timestamps external events with it. An asynchronous capture pin (typically routed from an mprj_io pad) is synchronized and edge-detected. On each qualifying edge, the current timer count is pushed into a small first-word-fall-through FIFO. Firmware drains the FIFO through a pop strobe; an interrupt and a sticky overflow flag report pending and lost captures.

Parameters:
WIDTH, 32, width of count_value and captured data
DEPTH, 4, FIFO entries; power of two, >= 2
SYNC_STAGES, 2, synchronizer flops on cap_in; >= 2

Ports:
wb_clk_i  input  1  single clock, all logic on rising edge
wb_rst_i  input  1  synchronous, active-high reset
enable  input  1  1 = captures allowed
edge_sel  input  2  00 none, 01 rising, 10 falling, 11 both
cap_in  input  1  asynchronous capture pin
count_value  input  WIDTH  live timer count from counter/timer block
pop  input  1  consume head entry
cap_data  output  WIDTH  head entry; 0 when empty
cap_valid  output  1  FIFO non-empty
level  output  $clog2(DEPTH)+1  entries held, 0..DEPTH
overflow  output  1  sticky: a capture was dropped
clr_overflow  input  1  clears overflow
irq  output  1  cap_valid | overflow, driven from flops only

Behaviour:
- Reset (wb_rst_i high at an edge): sync chain, prev flop, FIFO pointers cleared; level=0, cap_valid=0, cap_data=0, overflow=0, irq=0. Memory contents are don't-care. Reset mid-operation discards all entries on that edge.
- Arm counter: after reset, edge detection is disarmed for SYNC_STAGES+1 cycles. While disarmed, prev tracks the synchronizer output every cycle, so a cap_in held high through reset produces no event.
- Synchronizer: s[0] samples cap_in; s[SYNC_STAGES-1] is the synchronized level. Prev is updated every cycle regardless of enable.
- Event condition: armed & enable & ((edge_sel[0] & s_last & ~prev) | (edge_sel[1] & ~s_last & prev)).
- Latency: if cap_in first samples the new level at edge N, the push happens at edge N+SYNC_STAGES and stores count_value as sampled on that edge. cap_valid rises after that edge.
- FIFO: first-word-fall-through. cap_data shows the head whenever cap_valid=1. pop with cap_valid=1 removes the head at the edge. pop when empty is ignored.
- Push with level<DEPTH: the entry is stored and level increments, unless a pop occurs in the same cycle, in which case level is unchanged.
- Push at level==DEPTH with pop: both are accepted, level stays DEPTH, no overflow.
- Push at level==DEPTH without pop: the value is dropped, contents are unchanged, and overflow is set.
- clr_overflow clears overflow at the next edge. If it coincides with a new drop, set wins.
- Pointers wrap modulo DEPTH. level is not computed from pointer difference alone; it is held in a separate counter or carries an extra pointer bit.
- enable=0: no pushes. Synchronizer and prev keep running, so re-enabling never creates an event from a stale level. FIFO contents, pop and overflow clear all keep working.
- edge_sel or enable changes take effect for events evaluated in the following cycle.
- irq is registered: irq equals cap_valid | overflow as of the previous edge's state, with no combinational path from any input.

Test Plan:
1. Single capture. Setup: edge_sel=01, count_value=0xdcba7cfb held, cap_in pulsed high for 5 cycles. Required: exactly 1 push; cap_data=0xdcba7cfb, level=1, cap_valid=1, irq=1; the falling edge is ignored. Then pop: level=0, cap_data=0, irq=0.
2. Latency. Setup: count_value increments by 1 each cycle from 0x1000, cap_in rises so it is first sampled at the edge where count_value=0x1005. Required: captured value 0x1007 with SYNC_STAGES=2.
3. Overflow. Setup: edge_sel=11, events with counts 0x19, 0x0f, 0x12bc, 0x5d, 0x259, no pops. Required: level=4, overflow=1; pops return 0x19, 0x0f, 0x12bc, 0x5d; 0x259 is lost. clr_overflow then gives overflow=0, with irq staying 1 until the FIFO is empty.
4. Full plus simultaneous pop and push at level 4. Required: level stays 4, overflow stays 0, the oldest entry leaves, and the new value appears after three more pops.
5. Reset cases. Hold cap_in=1 through reset release: no capture within 20 cycles. Apply reset while level=3 and overflow=1: the next cycle shows level=0, cap_valid=0, overflow=0, irq=0.
6. Enable gating. With enable=0, toggle cap_in 8 times: level=0. Leave cap_in high and set enable=1: no capture. Then a falling edge with edge_sel=10 produces exactly 1 capture.
